mem_stage_wbuf: RTL and testbench



---
 rtl/mem_stage_wbuf.sv | 165 ++++++++++++++++
 tb/tb_mem_stage_wbuf.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_wbuf.sv
// Memory stage with a posted write buffer in front of a single-port backend.
// Loads forward from the newest buffered store or go to the backend ahead of drains.
module mem_stage_wbuf #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WB_EN_IN,
    input  logic          Mem_R_EN,
    input  logic          Mem_W_EN,
    input  logic [AW-1:0] ALU_res,
    input  logic [DW-1:0] Val_Rm,
    output logic          WB_EN_OUT,
    output logic [DW-1:0] data_mem,
    output logic          Ready,
    output logic          buf_empty,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    localparam int OFS = $clog2(DW / 8);
    localparam int TW  = AW - OFS;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    state_t        r_state;
    logic [TW-1:0] r_tag  [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          w_store;
    logic          w_load;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_hit;
    logic          w_miss;
    logic          w_rd_done;
    logic [DW-1:0] w_fwd;
    logic [TW-1:0] w_ld_tag;
    logic [AW-1:0] w_rd_addr;
    logic [PW-1:0] w_next_head;
    logic          w_unused;

    assign w_ld_tag    = ALU_res[AW-1:OFS];
    assign w_rd_addr   = {w_ld_tag, {OFS{1'b0}}};
    assign w_unused    = ^ALU_res[OFS-1:0];
    assign w_next_head = r_rd_ptr + PW'(1);
    assign w_store     = Mem_W_EN;
    assign w_load      = Mem_R_EN && !Mem_W_EN;
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_pop       = (r_state == S_WR) && mem_ready;
    assign w_rd_done   = (r_state == S_RD) && mem_ready;
    assign w_push      = w_store && (!w_full || w_pop);
    assign w_miss      = w_load && !w_hit;

    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx = r_rd_ptr;
        w_hit = 1'b0;
        w_fwd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_rd_ptr + PW'(i);
            if (CW'(i) < r_count && r_tag[v_idx] == w_ld_tag) begin
                w_hit = 1'b1;
                w_fwd = r_data[v_idx];
            end
        end
    end

    assign Ready     = w_store ? w_push : (w_miss ? w_rd_done : 1'b1);
    assign data_mem  = (w_load && w_hit) ? w_fwd :
                       ((w_miss && w_rd_done) ? mem_rdata : '0);
    assign WB_EN_OUT = WB_EN_IN && Ready;
    assign buf_empty = (r_count == '0) && (r_state != S_WR);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wr_ptr]  <= w_ld_tag;
            r_data[r_wr_ptr] <= Val_Rm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_next_head;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            unique case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_state    <= S_RD;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_rd_addr;
                    end else if (r_count != '0) begin
                        r_state     <= S_WR;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {r_tag[r_rd_ptr], {OFS{1'b0}}};
                        r_mem_wdata <= r_data[r_rd_ptr];
                    end
                end
                S_WR: begin
                    // A write in flight always completes before a read is issued.
                    if (mem_ready) begin
                        if (w_miss) begin
                            r_state    <= S_RD;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_rd_addr;
                        end else if (r_count > CW'(1)) begin
                            r_mem_addr  <= {r_tag[w_next_head], {OFS{1'b0}}};
                            r_mem_wdata <= r_data[w_next_head];
                        end else begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_wbuf.sv
// Bench for mem_stage_wbuf: directed scenarios plus a randomized run
// against a queue-based model of the write buffer.
module tb_mem_stage_wbuf;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_IN;
    logic        Mem_R_EN;
    logic        Mem_W_EN;
    logic [31:0] ALU_res;
    logic [31:0] Val_Rm;
    logic        WB_EN_OUT;
    logic [31:0] data_mem;
    logic        Ready;
    logic        buf_empty;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [29:0] tag;
        logic [31:0] data;
    } ent_t;

    mem_stage_wbuf #(.AW(32), .DW(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .WB_EN_IN  (WB_EN_IN),
        .Mem_R_EN  (Mem_R_EN),
        .Mem_W_EN  (Mem_W_EN),
        .ALU_res   (ALU_res),
        .Val_Rm    (Val_Rm),
        .WB_EN_OUT (WB_EN_OUT),
        .data_mem  (data_mem),
        .Ready     (Ready),
        .buf_empty (buf_empty),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    // Drive one cycle of inputs at the falling edge, settle, then return for checks.
    task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic [31:0] rd);
        @(negedge clk);
        Mem_R_EN  = r;
        Mem_W_EN  = w;
        ALU_res   = a;
        Val_Rm    = d;
        mem_ready = rdy;
        mem_rdata = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        Mem_R_EN = 0; Mem_W_EN = 0; mem_ready = 0; WB_EN_IN = 0;
        ALU_res = 0; Val_Rm = 0; mem_rdata = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        WB_EN_IN = 1'b1;
        #1;
        checks++;
        if (Ready !== 1'b1 || buf_empty !== 1'b1 || WB_EN_OUT !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: got Ready=%b empty=%b wb=%b want 1 1 1",
                     Ready, buf_empty, WB_EN_OUT);
        end
        checks++;
        if (mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0 || data_mem !== 0) begin
            errors++;
            $display("FAIL reset_bus: got req=%b we=%b addr=%h wd=%h dm=%h want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, data_mem);
        end
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (mem_req !== 1'b0 || buf_empty !== 1'b1 || data_mem !== 0) begin
            errors++;
            $display("FAIL idle_ready_ignored: got req=%b empty=%b dm=%h want 0 1 0",
                     mem_req, buf_empty, data_mem);
        end
        WB_EN_IN = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'h14; exp_a[1] = 32'h18; exp_a[2] = 32'h1C; exp_a[3] = 32'h20;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 32'h10 + 32'(i * 4), 32'hD000_0010 + 32'(i * 4), 0, 0);
            checks++;
            if (Ready !== 1'b1) begin
                errors++;
                $display("FAIL full_store%0d: got Ready=%b want 1", i, Ready);
            end
        end
        cyc(0, 1, 32'h20, 32'hD000_0020, 0, 0);
        checks++;
        if (Ready !== 1'b0) begin
            errors++;
            $display("FAIL full_fifth_stall: got Ready=%b want 0", Ready);
        end
        cyc(0, 1, 32'h20, 32'hD000_0020, 1, 0);
        checks++;
        if (Ready !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL full_drain_accept: got Ready=%b req=%b we=%b addr=%h want 1 1 1 00000010",
                     Ready, mem_req, mem_we, mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_a[i] ||
                mem_wdata !== (32'hD000_0000 | exp_a[i])) begin
                errors++;
                $display("FAIL full_drain_order%0d: got req=%b we=%b addr=%h wd=%h want 1 1 %h %h",
                         i, mem_req, mem_we, mem_addr, mem_wdata, exp_a[i], 32'hD000_0000 | exp_a[i]);
            end
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (buf_empty !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_drained_empty: got empty=%b req=%b want 1 0", buf_empty, mem_req);
        end
    endtask

    task automatic test_forward();
        do_reset();
        cyc(0, 1, 32'h40, 32'hAAAA_0001, 0, 0);
        cyc(0, 1, 32'h40, 32'hBBBB_0002, 0, 0);
        cyc(1, 0, 32'h40, 0, 0, 32'h5555_5555);
        checks++;
        if (Ready !== 1'b1 || data_mem !== 32'hBBBB_0002) begin
            errors++;
            $display("FAIL fwd_newest: got Ready=%b dm=%h want 1 bbbb0002", Ready, data_mem);
        end
        cyc(1, 0, 32'h43, 0, 0, 0);
        checks++;
        if (Ready !== 1'b1 || data_mem !== 32'hBBBB_0002) begin
            errors++;
            $display("FAIL fwd_byte_offset: got Ready=%b dm=%h want 1 bbbb0002", Ready, data_mem);
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40) begin
            errors++;
            $display("FAIL fwd_no_read: got req=%b we=%b addr=%h want 1 1 00000040",
                     mem_req, mem_we, mem_addr);
        end
        cyc(1, 0, 32'h44, 0, 0, 0);
        checks++;
        if (Ready !== 1'b0 || data_mem !== 0) begin
            errors++;
            $display("FAIL fwd_neighbour_miss: got Ready=%b dm=%h want 0 0", Ready, data_mem);
        end
    endtask

    task automatic test_load_priority();
        do_reset();
        cyc(0, 1, 32'h10, 32'h1, 0, 0);
        cyc(0, 1, 32'h14, 32'h2, 0, 0);
        cyc(0, 1, 32'h18, 32'h3, 0, 0);
        WB_EN_IN = 1'b1;
        cyc(1, 0, 32'h80, 0, 0, 0);
        checks++;
        if (Ready !== 1'b0 || WB_EN_OUT !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL prio_stall_wr: got Ready=%b wb=%b we=%b addr=%h want 0 0 1 00000010",
                     Ready, WB_EN_OUT, mem_we, mem_addr);
        end
        cyc(1, 0, 32'h80, 0, 1, 0);
        checks++;
        if (Ready !== 1'b0 || WB_EN_OUT !== 1'b0) begin
            errors++;
            $display("FAIL prio_wr_done: got Ready=%b wb=%b want 0 0", Ready, WB_EN_OUT);
        end
        cyc(1, 0, 32'h80, 0, 0, 0);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h80 || Ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_read_first: got req=%b we=%b addr=%h Ready=%b want 1 0 00000080 0",
                     mem_req, mem_we, mem_addr, Ready);
        end
        cyc(1, 0, 32'h80, 0, 1, 32'h1234_5678);
        checks++;
        if (Ready !== 1'b1 || data_mem !== 32'h1234_5678 || WB_EN_OUT !== 1'b1) begin
            errors++;
            $display("FAIL prio_read_data: got Ready=%b dm=%h wb=%b want 1 12345678 1",
                     Ready, data_mem, WB_EN_OUT);
        end
        WB_EN_IN = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h14 || mem_wdata !== 32'h2) begin
            errors++;
            $display("FAIL prio_resume_drain: got req=%b we=%b addr=%h wd=%h want 1 1 00000014 00000002",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(0, 1, 32'h100, 32'hA, 0, 0);
        cyc(0, 1, 32'h104, 32'hB, 0, 0);
        cyc(0, 1, 32'h108, 32'hC, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (buf_empty !== 1'b1 || mem_req !== 1'b0 || Ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_flush: got empty=%b req=%b Ready=%b want 1 0 1",
                     buf_empty, mem_req, Ready);
        end
        cyc(1, 0, 32'h104, 0, 0, 0);
        checks++;
        if (Ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_fwd: got Ready=%b want 0", Ready);
        end
        cyc(1, 0, 32'h104, 0, 1, 32'hCAFE_F00D);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h104 ||
            Ready !== 1'b1 || data_mem !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rstmid_backend: got req=%b we=%b addr=%h Ready=%b dm=%h want 1 0 00000104 1 cafef00d",
                     mem_req, mem_we, mem_addr, Ready, data_mem);
        end
    endtask

    task automatic test_random();
        ent_t        q[$];
        logic        op_r, op_w, prev_ready, pop, hit, exp_r, bad;
        logic [31:0] op_a, op_d, fd, exp_d;
        int          k, stall;
        do_reset();
        prev_ready = 1'b1;
        stall = 0;
        op_r = 0; op_w = 0; op_a = 0; op_d = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (prev_ready) begin
                k    = $urandom_range(0, 3);
                op_w = (k == 1 || k == 3);
                op_r = (k >= 2);
                op_a = 32'h200 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
                op_d = $urandom;
                WB_EN_IN = 1'($urandom_range(0, 1));
            end
            Mem_W_EN  = op_w;
            Mem_R_EN  = op_r;
            ALU_res   = op_a;
            Val_Rm    = op_d;
            mem_ready = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
            #1;
            pop = mem_req && mem_we && mem_ready;
            if (mem_req && mem_we) begin
                bad = (q.size() == 0);
                if (!bad) bad = (mem_addr !== {q[0].tag, 2'b00}) || (mem_wdata !== q[0].data);
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL rnd_drain_head: got addr=%h wd=%h want oldest queued entry (size %0d)",
                             mem_addr, mem_wdata, q.size());
                end
            end
            if (mem_req && !mem_we) begin
                checks++;
                if (!(op_r && !op_w) || mem_addr !== {op_a[31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL rnd_read_addr: got addr=%h want %h", mem_addr, {op_a[31:2], 2'b00});
                end
            end
            hit = 1'b0;
            fd  = 0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].tag == op_a[31:2]) begin
                    hit = 1'b1;
                    fd  = q[i].data;
                    break;
                end
            end
            if (op_w) begin
                exp_r = (q.size() < DEPTH) || pop;
                exp_d = 0;
            end else if (op_r && hit) begin
                exp_r = 1'b1;
                exp_d = fd;
            end else if (op_r) begin
                exp_r = mem_req && !mem_we && mem_ready;
                exp_d = exp_r ? mem_rdata : 32'h0;
            end else begin
                exp_r = 1'b1;
                exp_d = 0;
            end
            checks++;
            if (Ready !== exp_r || data_mem !== exp_d || WB_EN_OUT !== (WB_EN_IN & exp_r)) begin
                errors++;
                $display("FAIL rnd_cycle%0d: got Ready=%b dm=%h wb=%b want %b %h %b",
                         n, Ready, data_mem, WB_EN_OUT, exp_r, exp_d, WB_EN_IN & exp_r);
            end
            checks++;
            if (buf_empty !== (q.size() == 0)) begin
                errors++;
                $display("FAIL rnd_empty%0d: got %b want %b", n, buf_empty, q.size() == 0);
            end
            if (pop) void'(q.pop_front());
            if (op_w && exp_r) q.push_back('{tag: op_a[31:2], data: op_d});
            prev_ready = Ready;
            stall = Ready ? 0 : stall + 1;
            if (stall > 64) begin
                errors++;
                $display("FAIL rnd_stall_bound: got %0d stalled cycles want <= 64", stall);
                break;
            end
            if (errors > 20) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        WB_EN_IN = 0; Mem_R_EN = 0; Mem_W_EN = 0;
        ALU_res = 0; Val_Rm = 0; mem_rdata = 0; mem_ready = 0;
        test_reset();
        test_full();
        test_forward();
        test_load_priority();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
